// File: rtl/oven_pkg.sv
// Shared types and helpers for the oven cook-cycle controller:
// state encoding, BCD digit / temperature widths, mm:ss timer struct.
package oven_pkg;

    localparam int DIGIT_W         = 4;
    localparam int TEMP_W          = 10;
    localparam int AMBIENT_DEFAULT = 70;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        PREHEAT = 3'd2,
        COOK    = 3'd3,
        PAUSED  = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t min_tens;
        digit_t min_ones;
        digit_t sec_tens;
        digit_t sec_ones;
    } mmss_t;

    // Saturate an entered digit to the largest legal value for its position
    function automatic digit_t clamp_digit(input digit_t d, input digit_t max_val);
        return (d > max_val) ? max_val : d;
    endfunction

    // Three already-clamped BCD digits to binary (0..999)
    function automatic logic [TEMP_W-1:0] bcd3_to_bin(input digit_t h, input digit_t t, input digit_t o);
        return TEMP_W'(h) * TEMP_W'(100) + TEMP_W'(t) * TEMP_W'(10) + TEMP_W'(o);
    endfunction

endpackage

// File: rtl/bcd_down_counter_mmss.sv
// Four-digit mm:ss BCD down-counter with clear, load, decrement-enable
// and a zero flag. Decrementing at 00:00 holds the count at 00:00.
module bcd_down_counter_mmss
    import oven_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  load,
    input  logic  dec,
    input  mmss_t load_val,
    output mmss_t count,
    output logic  zero
);

    mmss_t count_dec;

    // Borrow chain: a zero digit wraps to its maximum and borrows from the digit above
    always_comb begin
        // NOTE: start from a full default so every path assigns every bit and no latch is inferred.
        count_dec = count;
        if (count.sec_ones != 4'd0) begin
            count_dec.sec_ones = count.sec_ones - 4'd1;
        end else begin
            count_dec.sec_ones = 4'd9;
            if (count.sec_tens != 4'd0) begin
                count_dec.sec_tens = count.sec_tens - 4'd1;
            end else begin
                count_dec.sec_tens = 4'd5;
                if (count.min_ones != 4'd0) begin
                    count_dec.min_ones = count.min_ones - 4'd1;
                end else begin
                    count_dec.min_ones = 4'd9;
                    count_dec.min_tens = count.min_tens - 4'd1;
                end
            end
        end
    end

    assign zero = (count == '0);

    // Count register: clear beats load beats decrement
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count_dec;
        end
    end

endmodule

// File: rtl/oven_cook_ctrl.sv
// Cook-cycle sequencer: latches setpoint and mm:ss time from digit entry,
// preheats a simulated cavity, counts the timer down in COOK, drives a
// bang-bang heater, handles door pause / cancel and the end-of-cycle beep.
module oven_cook_ctrl
    import oven_pkg::*;
#(
    parameter int HEAT_STEP  = 25,
    parameter int COOL_STEP  = 10,
    parameter int AMBIENT    = AMBIENT_DEFAULT,
    parameter int BEEP_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              entry_done,
    input  logic [3:0]        temp_d2,
    input  logic [3:0]        temp_d1,
    input  logic [3:0]        temp_d0,
    input  logic [3:0]        time_d3,
    input  logic [3:0]        time_d2,
    input  logic [3:0]        time_d1,
    input  logic [3:0]        time_d0,
    input  logic              start_btn,
    input  logic              cancel_btn,
    input  logic              door_open,
    output logic              heater_on,
    output logic              beep,
    output logic [3:0]        rem_d3,
    output logic [3:0]        rem_d2,
    output logic [3:0]        rem_d1,
    output logic [3:0]        rem_d0,
    output logic [TEMP_W-1:0] oven_temp,
    output logic [2:0]        state_o
);

    localparam int                BEEP_W     = $clog2(BEEP_TICKS + 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST  = BEEP_W'(BEEP_TICKS - 1);
    localparam logic [TEMP_W-1:0] AMB_T      = TEMP_W'(AMBIENT);
    localparam logic [TEMP_W-1:0] COOL_T     = TEMP_W'(COOL_STEP);
    localparam logic [TEMP_W-1:0] COOL_FLOOR = TEMP_W'(AMBIENT + COOL_STEP);

    state_t              state;
    logic [TEMP_W-1:0]   setpoint;
    logic [BEEP_W-1:0]   beep_cnt;

    mmss_t               rem;
    mmss_t               load_val;
    logic                cnt_zero;
    logic                cnt_one;
    logic                cnt_clr;
    logic                cnt_load;
    logic                cnt_dec;

    logic [TEMP_W-1:0]   entry_setpoint;
    logic [TEMP_W:0]     heat_sum;
    logic [TEMP_W-1:0]   heat_next;
    logic [TEMP_W-1:0]   cool_next;

    logic                cancel_hit;
    logic                start_ok;
    logic                temp_low;

    // Entered digits are clamped before they reach either the timer or the setpoint
    assign load_val.min_tens = clamp_digit(time_d3, 4'd9);
    assign load_val.min_ones = clamp_digit(time_d2, 4'd9);
    assign load_val.sec_tens = clamp_digit(time_d1, 4'd5);
    assign load_val.sec_ones = clamp_digit(time_d0, 4'd9);
    assign entry_setpoint    = bcd3_to_bin(clamp_digit(temp_d2, 4'd9),
                                           clamp_digit(temp_d1, 4'd9),
                                           clamp_digit(temp_d0, 4'd9));

    assign cancel_hit = cancel_btn && (state != IDLE);
    assign start_ok   = start_btn && !door_open && !cnt_zero;
    assign temp_low   = (oven_temp < setpoint);
    assign cnt_one    = (rem == mmss_t'(16'h0001));

    // Saturating heat step and ambient-floored cool step
    assign heat_sum  = {1'b0, oven_temp} + (TEMP_W+1)'(HEAT_STEP);
    assign heat_next = (heat_sum > {1'b0, setpoint}) ? setpoint : heat_sum[TEMP_W-1:0];
    assign cool_next = (oven_temp >= COOL_FLOOR) ? (oven_temp - COOL_T) : AMB_T;

    // Timer strobes, following the same priority as the state machine below
    always_comb begin
        cnt_clr  = cancel_hit;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (!cancel_hit) begin
            case (state)
                IDLE:    cnt_load = entry_done;
                ARMED:   cnt_load = entry_done && !start_ok;
                COOK:    cnt_dec  = tick_1hz && !door_open;
                default: ;
            endcase
        end
    end

    bcd_down_counter_mmss u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (load_val),
        .count    (rem),
        .zero     (cnt_zero)
    );

    // Setpoint latch: captured together with the timer digits
    always_ff @(posedge clk) begin
        if (rst) begin
            setpoint <= '0;
        end else if (cnt_load) begin
            setpoint <= entry_setpoint;
        end
    end

    // Cavity model: once per second, heat toward setpoint or cool toward ambient
    always_ff @(posedge clk) begin
        if (rst) begin
            oven_temp <= AMB_T;
        end else if (tick_1hz) begin
            oven_temp <= heater_on ? heat_next : cool_next;
        end
    end

    // Sequencer with registered heater/beep; heater only stays on while remaining in PREHEAT/COOK
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            heater_on <= 1'b0;
            beep      <= 1'b0;
            beep_cnt  <= '0;
        end else begin
            heater_on <= 1'b0;
            beep      <= 1'b0;
            if (cancel_hit) begin
                state    <= IDLE;
                beep_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (entry_done) state <= ARMED;
                    end
                    ARMED: begin
                        if (start_ok) state <= PREHEAT;
                    end
                    PREHEAT: begin
                        if (door_open) begin
                            state <= PAUSED;
                        end else begin
                            heater_on <= temp_low;
                            if (!temp_low) state <= COOK;
                        end
                    end
                    COOK: begin
                        if (door_open) begin
                            state <= PAUSED;
                        end else if (tick_1hz && (cnt_one || cnt_zero)) begin
                            state    <= DONE;
                            beep     <= 1'b1;
                            beep_cnt <= '0;
                        end else begin
                            heater_on <= temp_low;
                        end
                    end
                    PAUSED: begin
                        if (start_btn && !door_open) state <= PREHEAT;
                    end
                    DONE: begin
                        if (tick_1hz && (beep_cnt == BEEP_LAST)) begin
                            state    <= IDLE;
                            beep_cnt <= '0;
                        end else begin
                            beep <= 1'b1;
                            if (tick_1hz) beep_cnt <= beep_cnt + BEEP_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rem_d3  = rem.min_tens;
    assign rem_d2  = rem.min_ones;
    assign rem_d1  = rem.sec_tens;
    assign rem_d0  = rem.sec_ones;
    assign state_o = state;

endmodule
